// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory completer.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int unsigned WAIT_W = 4;

  // The WAIT register occupies the last word of the region.
  localparam int unsigned WAIT_IDX_OFFSET = 1;

  function automatic int unsigned wait_idx(input int unsigned mem_words);
    return mem_words - WAIT_IDX_OFFSET;
  endfunction

endpackage

// File: rtl/apb_slave_ram.sv
// Single-port word RAM: synchronous write, asynchronous read, no reset.
module apb_slave_ram #(
  parameter int DEPTH      = 63,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  in_range;

  assign in_range = (32'(addr) < DEPTH);

  // NOTE: storage arrays get no reset; clearing them would turn the array into flops with a reset tree.
  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = in_range ? mem[addr] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer: word RAM plus a WAIT register that sets the number of wait states per transfer.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter logic [31:0]       BASE_ADDR  = 32'h000,
  parameter int                MEM_WORDS  = 64,
  parameter int                ADDR_WIDTH = 32,
  parameter int                DATA_WIDTH = 32,
  parameter logic [WAIT_W-1:0] WAIT_RESET = 4'd0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int                    IDX_W     = $clog2(MEM_WORDS);
  localparam int                    OFF_W     = ADDR_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [OFF_W-1:0]      WORDS_LIM = OFF_W'(MEM_WORDS);
  localparam logic [IDX_W-1:0]      WAIT_IDX  = IDX_W'(wait_idx(MEM_WORDS));

  apb_state_e            state_q, state_d;
  logic [WAIT_W-1:0]     cnt_q,   cnt_d;
  logic [WAIT_W-1:0]     wait_q,  wait_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q,   err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [OFF_W-1:0]      dec_word;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic                  complete;
  logic                  commit;
  logic                  ram_we;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign dec_word = OFF_W'((PADDR - BASE) >> 2);
  assign dec_idx  = dec_word[IDX_W-1:0];
  assign dec_err  = (PADDR < BASE) | (dec_word >= WORDS_LIM) | (PADDR[1:0] != 2'b00);

  // Completion and write enable depend only on registered state and the handshake lines.
  assign complete = (state_q == ACCESS) & PSEL & PENABLE & (cnt_q == '0);
  assign commit   = complete & write_q & ~err_q & ~HRESET;
  assign ram_we   = commit & (idx_q != WAIT_IDX);

  // A write commits in an access cycle and a setup read happens with PENABLE low, so they never collide.
  assign ram_addr = ram_we ? idx_q : dec_idx;

  apb_slave_ram #(
    .DEPTH      (MEM_WORDS - 1),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (IDX_W)
  ) u_ram (
    .clk   (HCLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // NOTE: every output and next-state value is defaulted first so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    write_d = write_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;

    if (PSEL && !PENABLE) begin
      // Setup: from IDLE, or abandoning an unfinished transfer while in ACCESS.
      state_d = ACCESS;
      idx_d   = dec_idx;
      write_d = PWRITE;
      wdata_d = PWDATA;
      err_d   = dec_err;
      cnt_d   = wait_q;
      rdata_d = (dec_idx == WAIT_IDX) ? DATA_WIDTH'(wait_q) : ram_rdata;
    end else begin
      case (state_q)
        IDLE: begin
          if (PSEL && PENABLE) begin
            PREADY  = 1'b1;
            PSLVERR = 1'b1;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state_d = IDLE;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WAIT_W'(1);
          end else begin
            state_d = IDLE;
            PREADY  = 1'b1;
            PSLVERR = err_q;
            if (!write_q && !err_q) begin
              PRDATA = rdata_q;
            end
            if (commit && (idx_q == WAIT_IDX)) begin
              wait_d = wdata_q[WAIT_W-1:0];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (HRESET) begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= WAIT_RESET;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

Single APB completer: a word-addressed RAM plus one wait-state control register. It sits directly downstream of the AHB-to-APB bridge and consumes one PSELx bit plus the shared PADDR/PWRITE/PWDATA/PENABLE. It returns PRDATA/PREADY/PSLVERR into the bridge's per-slave input slots. One instance is placed per bridge slave region; it is also the standard bench completer for the bridge.

## Interface
- BASE_ADDR, 32'h000: first byte address of the region. Must match the bridge's SLAVE_START_ADDR_n.
- MEM_WORDS, 64: 32-bit words in the region (256 bytes).
  - Words 0..MEM_WORDS-2 are RAM.
  - Word MEM_WORDS-1 is the WAIT register.
- ADDR_WIDTH, 32: PADDR width.
- DATA_WIDTH, 32: PWDATA/PRDATA width.
- WAIT_RESET, 4'd0: reset value of the WAIT register.

Ports:
- HCLK  in  1  clock; shared with the bridge.
- HRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  this slave's PSELx bit.
- PENABLE  in  1  access phase.
- PADDR  in  ADDR_WIDTH  byte address.
- PWRITE  in  1  1=write, 0=read.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data; 0 unless a read completes.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error; only ever high together with PREADY.

## Operation
- Address decode: off = PADDR − BASE_ADDR; idx = off[ADDR_WIDTH-1:2].
  - err_addr = (PADDR < BASE_ADDR) | (idx ≥ MEM_WORDS) | (PADDR[1:0] ≠ 0).
  - Decode is evaluated in the setup cycle and latched with the other transfer attributes.
- FSM states: IDLE, ACCESS.
  - IDLE: on PSEL & !PENABLE (setup), do all of the following, then go to ACCESS:
    - latch idx, PWRITE, PWDATA, err_addr;
    - load cnt ← WAIT[3:0];
    - load rdata_q ← (idx == MEM_WORDS-1) ? {28'b0, WAIT} : ram[idx].
  - ACCESS, PSEL & PENABLE & cnt≠0: cnt decrements; stay in ACCESS.
  - ACCESS, PSEL & PENABLE & cnt==0: PREADY=1 (completion). Next state is IDLE; the next setup is decoded from IDLE.
  - ACCESS, !PSEL: abort. Go to IDLE; no write, no PREADY.
  - ACCESS, PSEL & !PENABLE (new setup without a completion): abandon the old transfer and treat this cycle as a setup.
  - IDLE, PSEL & PENABLE (access without setup): protocol error. PREADY=1 and PSLVERR=1 in that cycle; no write; stay in IDLE.
- Completion:
  - PSLVERR = latched err_addr.
  - Read: PRDATA = err ? 0 : rdata_q.
  - Write: on the completing edge, if !err, write latched PWDATA into ram[idx] or WAIT (bits 3:0; upper bits ignored).
- WAIT register: 4 bits, reset to WAIT_RESET. A write to WAIT affects transfers whose setup is after the write's completion.
- Reset: state IDLE, cnt 0, WAIT=WAIT_RESET. RAM contents are not cleared.

## Timing
- Reset values: PREADY 0, PSLVERR 0, PRDATA 0.
- PREADY, PSLVERR and PRDATA are combinational from registered state (state, cnt, latched attributes) and PSEL/PENABLE; there is no path from PADDR/PWDATA.
- With WAIT=N, a transfer takes 1 setup cycle plus N+1 access cycles. PREADY is high in the (N+1)th access cycle.
- Write-to-read, same address, back-to-back: the write commits at the completing edge; the following setup reads the new value. No hazard.
- HRESET asserted in ACCESS: PREADY is 0 from the next cycle; a pending write is discarded.

## Structure
- Package apb_pkg:
  - apb_state_e {IDLE, ACCESS};
  - WAIT_W=4;
  - constant for the WAIT register index offset (MEM_WORDS-1).
- Sub-module apb_slave_ram:
  - single-port, synchronous write, asynchronous read;
  - DEPTH=MEM_WORDS-1;
  - no reset.
- FSM, decode, wait counter and WAIT register live in apb_slave_mem.

## Test plan
1. Reset, WAIT=0: write 0xDEADBEEF to 0x010, then read 0x010. Each transfer has PREADY in its first access cycle; PRDATA=0xDEADBEEF; PSLVERR=0.
2. Write 5 to WAIT (0x0FC, BASE 0), then read 0x010. PREADY is low for 5 access cycles and high on the 6th; reading 0x0FC returns 0x00000005.
3. Read 0x102 (misaligned) and 0x100 (out of range, MEM_WORDS=64). Each gives PREADY=1, PSLVERR=1, PRDATA=0. Write 0x12345678 to 0x100, then read 0x000: RAM is unchanged.
4. WAIT=3, write in progress: drop PSEL after the 2nd access cycle. No PREADY. The following read of that address returns the old value.
5. WAIT=2: assert HRESET in the 2nd access cycle. The next cycle has PREADY=0 and PSLVERR=0; WAIT reads back WAIT_RESET; RAM data written before reset is intact.
6. PSEL=1 and PENABLE=1 from IDLE with no setup cycle. PREADY=1 and PSLVERR=1 in that cycle; no write occurs.
